sisc_mem_arbiter: RTL
=====================

# sisc_mem_arbiter

Two-port arbiter and wait-state sequencer for the SISC single-ported memory. It shares the memory between the instruction-fetch requester (driven from the control FSM's fetch state) and the data requester (LOD/STR in the mem state). Each access is held for a programmable number of wait cycles and completed with a one-cycle done pulse. The block sits between the control FSM / datapath and the memory array.

## Interface
- AW, 16, address width
- DW, 32, data width
- WAIT, 2, extra memory wait cycles per access; legal 0..15
- clk  input  1  clock; all state changes on posedge
- rst_f  input  1  reset; asynchronous, active-low
- if_req  input  1  fetch request, level, held until if_done
- if_addr  input  AW  fetch address
- if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  output  DW  fetched word, held until next fetch completes
- ds_req  input  1  data request, level, held until ds_done
- ds_we  input  1  1 = store (STR), 0 = load (LOD)
- ds_addr  input  AW  data address
- ds_wdata  input  DW  store data
- ds_done  output  1  one-cycle pulse: data access complete
- ds_rdata  output  DW  load data, held until next load completes
- mem_en  output  1  memory enable
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, ACCESS, DONE. Encoded in 2 bits; unused encoding → IDLE.
- IDLE: sample if_req/ds_req each posedge.
  - Neither asserted → stay in IDLE.
  - One asserted → grant it.
  - Both asserted → grant the requester not granted last (round-robin).
- On grant, register owner, mem_addr, mem_we (ds_we for data, 0 for fetch) and mem_wdata (ds_wdata, or 0 for fetch). Load wait counter with WAIT and go to ACCESS.
- ACCESS: mem_en=1; mem_addr/mem_we/mem_wdata stay stable.
  - Counter ≠ 0 → decrement and stay.
  - Counter = 0 → capture mem_rdata into if_rdata (fetch owner) or ds_rdata (data load; stores leave ds_rdata unchanged). Set last-granted = owner and go to DONE.
- DONE: mem_en=0, mem_we=0. Owner's done=1 for exactly this cycle. No arbitration. → IDLE.
- Requester contract: deassert req at the posedge ending its done cycle. Req still high in IDLE is treated as a new request.
- Requester inputs are ignored outside IDLE. A req dropped mid-access does not abort it: the access completes and done pulses.
- Only the granted requester's done ever pulses; if_done and ds_done are never high together.

## Timing
- Reset (async, rst_f=0): state IDLE, counter 0, last-granted = data (first tie goes to fetch).
  - All outputs 0: if_done, ds_done, if_rdata, ds_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
- Reset mid-ACCESS or in DONE aborts immediately: mem_en/mem_we drop asynchronously and no done pulses.
- Request seen high at posedge k (in IDLE):
  - mem_en high cycles k+1 … k+1+WAIT (WAIT+1 cycles).
  - mem_rdata sampled at the posedge ending cycle k+1+WAIT.
  - done high in cycle k+2+WAIT.
  - IDLE again in cycle k+3+WAIT.
- Latency from grant edge to done = WAIT+2 cycles. Throughput = one access per WAIT+3 cycles.
- WAIT=0: ACCESS lasts exactly 1 cycle.
- All outputs are registered; no combinational path from req to mem_* or done.
- Store: mem_we high for all WAIT+1 ACCESS cycles; memory commits on the last.

## Test plan
- Reset: rst_f=0 mid-ACCESS → mem_en=0, busy=0 at once; no done; after release, outputs all 0 and state IDLE.
- Single fetch, WAIT=2: if_req at edge 0, addr 0x0010, mem returns 0x8123_0004 → mem_en cycles 1-3, if_done cycle 4, if_rdata=0x8123_0004, busy low cycle 5.
- Store then load, WAIT=2: ds_we=1, addr 0x0040, data 0xDEAD_BEEF → mem_we=1 cycles 1-3, ds_done cycle 4, ds_rdata unchanged. Load 0x0040 → ds_rdata=0xDEAD_BEEF.
- Tie after reset: if_req and ds_req both high at edge 0 → fetch served first (if_done cycle 4). Data granted at edge 5, ds_done cycle 9. Next tie goes to fetch again (last-granted = data).
- Back-to-back data requests with if_req constantly high → grants alternate fetch/data; neither requester waits more than one access.
- WAIT=0 and WAIT=15: done at grant+2 and grant+17 cycles respectively. A req dropped mid-ACCESS still produces done.

Source files
------------

// File: rtl/sisc_mem_arbiter.sv
// Round-robin arbiter and wait-state sequencer that shares the SISC single-ported
// memory between instruction fetch and LOD/STR data accesses.
module sisc_mem_arbiter #(
  parameter int AW   = 16,
  parameter int DW   = 32,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          ds_req,
  input  logic          ds_we,
  input  logic [AW-1:0] ds_addr,
  input  logic [DW-1:0] ds_wdata,
  output logic          ds_done,
  output logic [DW-1:0] ds_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    waitCnt_q;
  logic          ownerData_q;
  logic          lastData_q;
  logic          ifDone_q;
  logic          dsDone_q;
  logic          memEn_q;
  logic          memWe_q;
  logic          busy_q;
  logic [AW-1:0] memAddr_q;
  logic [DW-1:0] memWdata_q;
  logic [DW-1:0] ifRdata_q;
  logic [DW-1:0] dsRdata_q;
  logic          grantData;

  // On a tie the data port wins only when fetch was the last one served.
  assign grantData = ds_req && (!if_req || !lastData_q);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= IDLE;
      waitCnt_q   <= '0;
      ownerData_q <= 1'b0;
      lastData_q  <= 1'b1;
      ifDone_q    <= 1'b0;
      dsDone_q    <= 1'b0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      busy_q      <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      ifRdata_q   <= '0;
      dsRdata_q   <= '0;
    end else begin
      ifDone_q <= 1'b0;
      dsDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req || ds_req) begin
            ownerData_q <= grantData;
            memAddr_q   <= grantData ? ds_addr : if_addr;
            memWe_q     <= grantData && ds_we;
            memWdata_q  <= grantData ? ds_wdata : '0;
            waitCnt_q   <= 4'(WAIT);
            memEn_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (waitCnt_q != 4'd0) begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end else begin
            // Final wait cycle: memory data is valid on this edge.
            if (ownerData_q) begin
              if (!memWe_q) dsRdata_q <= mem_rdata;
              dsDone_q <= 1'b1;
            end else begin
              ifRdata_q <= mem_rdata;
              ifDone_q  <= 1'b1;
            end
            lastData_q <= ownerData_q;
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            state_q    <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          memEn_q <= 1'b0;
          memWe_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_done   = ifDone_q;
  assign ds_done   = dsDone_q;
  assign if_rdata  = ifRdata_q;
  assign ds_rdata  = dsRdata_q;
  assign mem_en    = memEn_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign busy      = busy_q;

endmodule
